// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: drains a 1-cycle-latency FIFO into a valid/ready stream.
// It has a 3-entry skid buffer, burst framing (m_last) and enable/flush control.
// Ports:
//   clk, rst (async, active-high)
//   en, flush                  : sequencer control
//   fifo_empty, fifo_underflow : FIFO status flags
//   fifo_data_out              : FIFO read data
//   fifo_rd_en                 : FIFO read request
//   m_valid, m_ready           : output stream handshake
//   m_data, m_last             : output stream payload
//   err, busy                  : status outputs
// Option: defining FIFO_RD_STREAM_STATS_EN adds the stat_words and stat_stalls counters.
`timescale 1ns/1ps
module fifo_rd_stream #(
   parameter int FIFO_WIDTH = 16,
   parameter int BURST_LEN  = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic                  flush,
   input  logic                  fifo_empty,
   input  logic                  fifo_underflow,
   input  logic [FIFO_WIDTH-1:0] fifo_data_out,
   output logic                  fifo_rd_en,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [FIFO_WIDTH-1:0] m_data,
   output logic                  m_last,
   output logic                  err,
   output logic                  busy
`ifdef FIFO_RD_STREAM_STATS_EN
   ,
   output logic [31:0]           stat_words,
   output logic [31:0]           stat_stalls
`endif
);

   localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
   localparam logic [BW-1:0] LAST = BW'(BURST_LEN - 1);

   typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_e;

   state_e                state_q, state_d;
   logic [1:0]            occ_q, occ_d;
   logic                  inflight_q;
   logic [BW-1:0]         beat_q, beat_d;
   logic                  err_q, err_d;
   logic [FIFO_WIDTH-1:0] buf_q [3];
   logic [FIFO_WIDTH-1:0] buf_d [3];
   logic [FIFO_WIDTH-1:0] nxt   [3];
   logic [FIFO_WIDTH-1:0] head;
   logic [2:0]            occ_sum;
   logic                  in_v, pop;

   // A landing word counts as present this cycle, so an empty buffer
   // forwards it directly and rd_en at N gives m_valid at N+1.
   assign in_v = inflight_q & ~fifo_underflow;
   assign head = (occ_q != 2'd0) ? buf_q[0] : fifo_data_out;
   assign pop  = m_valid & m_ready;
   assign occ_sum = {1'b0, occ_q} + 3'(in_v) - 3'(pop);

   // state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= RUN;
      else     state_q <= state_d;
   end

   // next state
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         RUN:   if (flush) state_d = FLUSH;
         FLUSH: if (!inflight_q) state_d = RUN;
         default: state_d = RUN;
      endcase
   end

   // outputs
   always_comb begin
      fifo_rd_en = 1'b0;
      m_valid    = 1'b0;
      busy       = (occ_q != 2'd0) | inflight_q;
      unique case (state_q)
         RUN: begin
            fifo_rd_en = ~rst & en & ~fifo_empty &
                         (({1'b0, occ_q} + 3'(inflight_q)) < 3'd3);
            m_valid    = (occ_q != 2'd0) | in_v;
         end
         FLUSH: busy = 1'b1;
         default: ;
      endcase
   end

   assign m_data = m_valid ? head : '0;
   assign m_last = m_valid & (beat_q == LAST);
   assign err    = err_q;

   // buffer and framing next state
   always_comb begin
      for (int i = 0; i < 3; i++) begin
         nxt[i] = buf_q[i];
         if (in_v && occ_q == 2'(i)) nxt[i] = fifo_data_out;
      end
      buf_d  = nxt;
      occ_d  = occ_q;
      beat_d = beat_q;
      err_d  = err_q | (inflight_q & fifo_underflow);
      if (state_q == RUN && !flush) begin
         occ_d = occ_sum[1:0];
         if (pop) begin
            buf_d[0] = nxt[1];
            buf_d[1] = nxt[2];
            beat_d   = (beat_q == LAST) ? '0 : beat_q + BW'(1);
         end
      end else begin
         occ_d  = 2'd0;
         beat_d = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         occ_q      <= 2'd0;
         inflight_q <= 1'b0;
         beat_q     <= '0;
         err_q      <= 1'b0;
         for (int i = 0; i < 3; i++) buf_q[i] <= '0;
      end else begin
         occ_q      <= occ_d;
         inflight_q <= fifo_rd_en;
         beat_q     <= beat_d;
         err_q      <= err_d;
         for (int i = 0; i < 3; i++) buf_q[i] <= buf_d[i];
      end
   end

   a_occ: assert property (@(posedge clk) disable iff (rst)
      (state_q == RUN) |-> (occ_sum <= 3'd3));

`ifdef FIFO_RD_STREAM_STATS_EN
   logic [31:0] words_q, stalls_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         words_q  <= '0;
         stalls_q <= '0;
      end else begin
         if (pop && words_q != '1) words_q <= words_q + 32'd1;
         if (m_valid && !m_ready && stalls_q != '1)
            stalls_q <= stalls_q + 32'd1;
      end
   end

   assign stat_words  = words_q;
   assign stat_stalls = stalls_q;
`endif

endmodule
